wallace_mac: RTL and testbench
==============================

# wallace_mac

Pipelined multiply-accumulate front end built around the existing combinational `wallace` 16x16 multiplier. It accepts a stream of unsigned 16-bit operand pairs over a valid/ready handshake and registers each pair into the multiplier inputs. It accumulates the 32-bit products into an ACC_W-bit accumulator and emits one dot-product result per N_TERMS accepted pairs on a valid/ready output. It sits directly upstream of `wallace`, which it feeds, and directly downstream of it, consuming its product.

## Interface
- ACC_W, 40: accumulator and result width; legal range 32..48.
- N_TERMS, 4: products summed per result; must be >= 1.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  16  unsigned multiplicand.
- in_b  input  16  unsigned multiplier.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result this cycle.
- out_sum  output  ACC_W  sum of N_TERMS products, truncated to ACC_W bits.
- out_ovf  output  1  a carry beyond ACC_W occurred while forming this out_sum.

## Operation
- stall = out_valid & ~out_ready. in_ready = ~rst & ~stall (combinational). in_ready does not depend on in_valid.
- Stage 1 (operand regs a_r, b_r, v1):
  - When ~stall: a_r/b_r <= in_a/in_b and v1 <= in_valid & in_ready.
  - When stall: hold all.
  - a_r and b_r drive the `wallace` instance. Its 32-bit product output s is the product used downstream.
  - The instance's second output is left unconnected.
- Stage 2 (accumulate): when ~stall & v1:
  - Form sum = acc + s, ACC_W+1 bits wide.
  - ovf_acc_next = ovf_acc | sum[ACC_W].
  - If cnt == N_TERMS-1 (last term):
    - out_sum <= sum[ACC_W-1:0], out_ovf <= ovf_acc_next, out_valid <= 1.
    - acc <= 0, ovf_acc <= 0, cnt <= 0.
  - Otherwise: acc <= sum[ACC_W-1:0], ovf_acc <= ovf_acc_next, cnt <= cnt+1.
- Output handshake:
  - out_valid & out_ready clears out_valid unless a new result loads on the same edge; in that case out_valid stays 1 and the new out_sum/out_ovf appear.
  - out_sum and out_ovf hold stable while out_valid & ~out_ready.
- cnt width: clog2(N_TERMS), minimum 1 bit. With N_TERMS=1, every product is a result.
- Reset: acc, ovf_acc, cnt, v1, a_r, b_r, out_valid, out_sum and out_ovf all go to 0. in_ready is 0 while rst is high. A partially accumulated dot product or a pending result is discarded on reset.

## Timing
- Pair accepted at edge E (in_valid & in_ready sampled high). Its product is accumulated at edge E+1.
- If that pair is the last term, out_valid is high after E+1: 2-cycle latency from acceptance to result.
- Throughput is one pair per cycle while out_ready is held high, including back-to-back results every N_TERMS cycles.
- Stall freezes both stages. A pair held in stage 1 is not lost or duplicated, and in_ready falls in the same cycle that stall asserts.
- in_valid low cycles (bubbles) do not advance cnt. Results are formed only from accepted pairs.
- The product path a_r/b_r -> `wallace` -> adder -> acc is single-cycle combinational and must close at the target clock.

## Test plan
- Reset with N_TERMS=4, ACC_W=40.
  - Stimulus: assert rst for 2 cycles mid-stream with 2 terms already accumulated, then release and feed 4 pairs.
  - Required: all outputs are 0 during reset, and in_ready is 0 while rst is high. The stale partial sum is discarded, so the first result is built only from the 4 pairs fed after reset.
- Dot product, N_TERMS=4, ACC_W=40, out_ready=1.
  - Stimulus: pairs (65535,65535), (25,25), (100,2), (45,2) on consecutive cycles.
  - Required: out_sum = 4294837140, out_ovf=0, out_valid high for exactly 1 cycle, 2 cycles after the last acceptance.
- Bubbles and backpressure.
  - Stimulus: same four pairs with in_valid gaps. Hold out_ready=0 for 3 cycles after out_valid rises while 4 more pairs (1,1) are offered.
  - Required: first out_sum = 4294837140 held stable for 4 cycles and in_ready=0 during the stall. Next result = 4 with no pair lost or duplicated.
- Overflow, N_TERMS=2, ACC_W=32.
  - Stimulus: (65535,65535) twice.
  - Required: out_sum = 4294705154, out_ovf=1. The next result from (1,1),(2,3) gives out_sum=7, out_ovf=0.
- N_TERMS=1, continuous stream.
  - Stimulus: (3,4), (0,65535), (65535,1).
  - Required: out_sum sequence 12, 0, 65535 on consecutive cycles. Simultaneous handshake and reload keeps out_valid high.

Source files
------------

// File: rtl/wallace_mac.sv
// Streaming multiply-accumulate around a carry-save 16x16 multiplier.
// Operands are registered into the multiplier and products are summed in groups of N_TERMS.

module wallace (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] s,
  output logic [31:0] c
);
  logic [31:0] row [16];
  logic [31:0] nxt [16];
  logic [31:0] x, y, z, maj;
  logic [4:0]  n, m, k;

  // Six 3:2 compressor layers reduce 16 rows: 16-11-8-6-4-3-2.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      row[i] = b[i] ? ({16'd0, a} << i) : 32'd0;
      nxt[i] = 32'd0;
    end
    n = 5'd16;
    m = 5'd0;
    k = 5'd0;
    x = 32'd0;
    y = 32'd0;
    z = 32'd0;
    maj = 32'd0;
    for (int l = 0; l < 6; l++) begin
      m = 5'd0;
      k = 5'd0;
      for (int i = 0; i < 16; i++) nxt[i] = 32'd0;
      for (int g = 0; g < 5; g++) begin
        if (5'(3 * g + 2) < n) begin
          x = row[3 * g];
          y = row[3 * g + 1];
          z = row[3 * g + 2];
          maj = (x & y) | (x & z) | (y & z);
          nxt[m[3:0]] = x ^ y ^ z;
          nxt[m[3:0] + 4'd1] = {maj[30:0], 1'b0};
          m = m + 5'd2;
          k = k + 5'd3;
        end
      end
      for (int r = 0; r < 16; r++) begin
        if (5'(r) >= k && 5'(r) < n) begin
          nxt[m[3:0]] = row[r];
          m = m + 5'd1;
        end
      end
      row = nxt;
      n = m;
    end
    s = row[0] + row[1];
    c = row[1];
  end
endmodule

module wallace_mac #(
  parameter int ACC_W   = 40,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  logic [15:0]      a_r, b_r;
  logic             v1;
  logic [31:0]      prod;
  logic [ACC_W-1:0] acc;
  logic             ovf_acc;
  logic [CNT_W-1:0] cnt;
  logic             stall;
  logic [ACC_W:0]   sum;

  wallace u_mul (
    .a(a_r),
    .b(b_r),
    .s(prod),
    .c()
  );

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~rst & ~stall;
  assign sum      = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      v1        <= 1'b0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (!stall) begin
        a_r <= in_a;
        b_r <= in_b;
        v1  <= in_valid & in_ready;
        // A result load on the same edge as a handshake overrides the clear above.
        if (v1) begin
          if (cnt == LAST) begin
            out_sum   <= sum[ACC_W-1:0];
            out_ovf   <= ovf_acc | sum[ACC_W];
            out_valid <= 1'b1;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= '0;
          end else begin
            acc     <= sum[ACC_W-1:0];
            ovf_acc <= ovf_acc | sum[ACC_W];
            cnt     <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_wallace_mac.sv
// Scoreboard bench for wallace_mac: three instances cover N_TERMS=4/40-bit, 2/32-bit and 1/40-bit.

module tb_wallace_mac;
  logic clk, rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [15:0] a_in_a, a_in_b;
  logic [39:0] a_out_sum;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_a, b_in_b;
  logic [31:0] b_out_sum;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
  logic [15:0] c_in_a, c_in_b;
  logic [39:0] c_out_sum;

  int n_checks = 0;
  int n_fail = 0;
  logic [64:0] qa[$], qb[$], qc[$];
  logic [64:0] ea, eb, ec;

  wallace_mac #(.ACC_W(40), .N_TERMS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf));

  wallace_mac #(.ACC_W(32), .N_TERMS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf));

  wallace_mac #(.ACC_W(40), .N_TERMS(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_a(c_in_a), .in_b(c_in_b), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected: got sum %0d with no expected result queued", a_out_sum);
      end else begin
        ea = qa.pop_front();
        check("a_sum", 64'(a_out_sum), ea[63:0]);
        check("a_ovf", 64'(a_out_ovf), 64'(ea[64]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected: got sum %0d with no expected result queued", b_out_sum);
      end else begin
        eb = qb.pop_front();
        check("b_sum", 64'(b_out_sum), eb[63:0]);
        check("b_ovf", 64'(b_out_ovf), 64'(eb[64]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL c_unexpected: got sum %0d with no expected result queued", c_out_sum);
      end else begin
        ec = qc.pop_front();
        check("c_sum", 64'(c_out_sum), ec[63:0]);
        check("c_ovf", 64'(c_out_ovf), 64'(ec[64]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    step();
  endtask

  task automatic drive_a(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic ordy, output logic acc);
    a_in_valid = v; a_in_a = x; a_in_b = y; a_out_ready = ordy;
    #1;
    acc = v & a_in_ready;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_b(input logic [15:0] x, input logic [15:0] y);
    b_in_valid = 1'b1; b_in_a = x; b_in_b = y; b_out_ready = 1'b1;
    step();
  endtask

  task automatic drive_c(input logic [15:0] x, input logic [15:0] y);
    c_in_valid = 1'b1; c_in_a = x; c_in_b = y; c_out_ready = 1'b1;
    step();
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && g < 40) begin
      idle();
      g++;
    end
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending a=%0d b=%0d c=%0d expected 0", qa.size(), qb.size(), qc.size());
    end
  endtask

  initial begin
    logic acc;
    int n_acc;
    int guard;
    rst = 1'b1;
    a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_out_ready = 1;
    c_in_valid = 0; c_in_a = 0; c_in_b = 0; c_out_ready = 1;

    // Reset values
    idle();
    repeat (2) begin
      idle();
      check("rst_a_out_valid", 64'(a_out_valid), 0);
      check("rst_a_out_sum", 64'(a_out_sum), 0);
      check("rst_a_out_ovf", 64'(a_out_ovf), 0);
      check("rst_a_in_ready", 64'(a_in_ready), 0);
      check("rst_b_out_valid", 64'(b_out_valid), 0);
      check("rst_c_out_valid", 64'(c_out_valid), 0);
    end
    rst = 1'b0;

    // Mid-stream reset with two terms accumulated
    drive_a(1, 16'd7, 16'd7, 1, acc);
    check("a_pre_accept", 64'(acc), 1);
    drive_a(1, 16'd9, 16'd9, 1, acc);
    idle();
    rst = 1'b1;
    repeat (2) begin
      #1;
      check("rst_mid_in_ready", 64'(a_in_ready), 0);
      idle();
      check("rst_mid_out_valid", 64'(a_out_valid), 0);
      check("rst_mid_out_sum", 64'(a_out_sum), 0);
    end
    rst = 1'b0;
    qa.push_back({1'b0, 64'd100});
    drive_a(1, 16'd1, 16'd2, 1, acc);
    drive_a(1, 16'd3, 16'd4, 1, acc);
    drive_a(1, 16'd5, 16'd6, 1, acc);
    drive_a(1, 16'd7, 16'd8, 1, acc);
    idle();
    wait_drain();

    // Dot product, latency and single-cycle valid
    qa.push_back({1'b0, 64'd4294837140});
    drive_a(1, 16'd65535, 16'd65535, 1, acc);
    drive_a(1, 16'd25, 16'd25, 1, acc);
    drive_a(1, 16'd100, 16'd2, 1, acc);
    drive_a(1, 16'd45, 16'd2, 1, acc);
    check("a_last_accept", 64'(acc), 1);
    check("a_lat_e0_valid", 64'(a_out_valid), 0);
    idle();
    check("a_lat_e1_valid", 64'(a_out_valid), 1);
    check("a_lat_e1_sum", 64'(a_out_sum), 64'd4294837140);
    idle();
    check("a_lat_e2_valid", 64'(a_out_valid), 0);
    wait_drain();

    // Bubbles and backpressure
    qa.push_back({1'b0, 64'd4294837140});
    drive_a(1, 16'd65535, 16'd65535, 1, acc);
    drive_a(0, 16'd0, 16'd0, 1, acc);
    drive_a(1, 16'd25, 16'd25, 1, acc);
    drive_a(0, 16'd0, 16'd0, 1, acc);
    drive_a(1, 16'd100, 16'd2, 1, acc);
    drive_a(1, 16'd45, 16'd2, 1, acc);
    qa.push_back({1'b0, 64'd4});
    drive_a(1, 16'd1, 16'd1, 1, acc);
    n_acc = int'(acc);
    check("a_bp_rise", 64'(a_out_valid), 1);
    check("a_bp_hold0", 64'(a_out_sum), 64'd4294837140);
    for (int k = 0; k < 3; k++) begin
      drive_a(1, 16'd1, 16'd1, 0, acc);
      check("a_bp_in_ready", 64'(acc), 0);
      check("a_bp_valid", 64'(a_out_valid), 1);
      check("a_bp_hold", 64'(a_out_sum), 64'd4294837140);
    end
    guard = 0;
    while (n_acc < 4 && guard < 20) begin
      drive_a(1, 16'd1, 16'd1, 1, acc);
      n_acc += int'(acc);
      guard++;
    end
    check("a_bp_accepts", 64'(n_acc), 4);
    idle();
    wait_drain();

    // Overflow with ACC_W=32, N_TERMS=2
    qb.push_back({1'b1, 64'd4294705154});
    qb.push_back({1'b0, 64'd7});
    drive_b(16'd65535, 16'd65535);
    drive_b(16'd65535, 16'd65535);
    drive_b(16'd1, 16'd1);
    drive_b(16'd2, 16'd3);
    idle();
    wait_drain();

    // N_TERMS=1 continuous stream
    qc.push_back({1'b0, 64'd12});
    qc.push_back({1'b0, 64'd0});
    qc.push_back({1'b0, 64'd65535});
    drive_c(16'd3, 16'd4);
    drive_c(16'd0, 16'd65535);
    check("c_seq0_valid", 64'(c_out_valid), 1);
    check("c_seq0_sum", 64'(c_out_sum), 64'd12);
    drive_c(16'd65535, 16'd1);
    check("c_seq1_valid", 64'(c_out_valid), 1);
    check("c_seq1_sum", 64'(c_out_sum), 64'd0);
    idle();
    check("c_seq2_valid", 64'(c_out_valid), 1);
    check("c_seq2_sum", 64'(c_out_sum), 64'd65535);
    idle();
    check("c_seq_end_valid", 64'(c_out_valid), 0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
